// File: rtl/gmii_pkg.sv
// Shared GMII constants and the receive/transmit FSM state encoding.
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          HDR_LEN       = 14;
    localparam logic [47:0] BCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_LEN,
        ST_PIX,
        ST_DROP
    } gmii_state_t;

endpackage

// File: rtl/gmii_rx_hdr_filter.sv
// Ethernet header filter: walks the 14 header bytes and checks the
// destination MAC (own address or broadcast) and the EtherType.
module gmii_rx_hdr_filter
    import gmii_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h00_37_FF_00_00_01,
    parameter logic [15:0] ETH_TYPE = 16'h88B5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] rx_byte,
    output logic       hdr_done,
    output logic       hdr_ok
);

    logic [3:0] idx;
    logic       mac_mis, bc_mis, type_mis;
    logic       mac_mis_nx, bc_mis_nx, type_mis_nx;

    // Byte i (0 = first on the wire) of a big-endian 48-bit address.
    function automatic logic [7:0] addr_byte(input logic [47:0] a, input logic [3:0] i);
        logic [47:0] s;
        s = a << (8 * i);
        return s[47:40];
    endfunction

    // Fold the current byte into the mismatch flags; own and broadcast
    // addresses are tracked separately so either one may match.
    always_comb begin
        mac_mis_nx  = mac_mis;
        bc_mis_nx   = bc_mis;
        type_mis_nx = type_mis;
        if (idx < 4'd6) begin
            mac_mis_nx = mac_mis | (rx_byte != addr_byte(MAC_ADDR, idx));
            bc_mis_nx  = bc_mis  | (rx_byte != addr_byte(BCAST_MAC, idx));
        end else if (idx == 4'd12) begin
            type_mis_nx = type_mis | (rx_byte != ETH_TYPE[15:8]);
        end else if (idx == 4'd13) begin
            type_mis_nx = type_mis | (rx_byte != ETH_TYPE[7:0]);
        end
    end

    assign hdr_done = en && (idx == 4'(HDR_LEN - 1));
    assign hdr_ok   = (!mac_mis_nx || !bc_mis_nx) && !type_mis_nx;

    // Byte index and latched mismatch flags; cleared whenever outside the header.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx      <= '0;
            mac_mis  <= 1'b0;
            bc_mis   <= 1'b0;
            type_mis <= 1'b0;
        end else if (en) begin
            idx      <= idx + 4'd1;
            mac_mis  <= mac_mis_nx;
            bc_mis   <= bc_mis_nx;
            type_mis <= type_mis_nx;
        end
    end

endmodule

// File: rtl/gmii_rx.sv
// GMII receiver: strips preamble/SFD, filters the header, reads a pixel
// count and packs 3-byte payload groups into 24-bit pixels for a FIFO.
module gmii_rx
    import gmii_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h00_37_FF_00_00_01,
    parameter logic [15:0] ETH_TYPE = 16'h88B5,
    parameter int          PRE_MIN  = 4,
    parameter int          MAX_PIX  = 1280
) (
    input  logic        rx_clk,
    input  logic        sys_rst,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    input  logic        full,
    output logic [23:0] din,
    output logic        wr_en,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] ovf_cnt
);

    localparam logic [2:0]  PRE_MIN_W = 3'(PRE_MIN);
    localparam logic [15:0] MAX_PIX_W = 16'(MAX_PIX);

    gmii_state_t state, state_nx;
    logic        wr_en_nx, done_nx, err_nx;
    logic [2:0]  pre_cnt;
    logic        len_ph;
    logic [7:0]  len_hi;
    logic [15:0] pix_n, pix_cnt;
    logic [1:0]  phase;
    logic [7:0]  r_byte, g_byte;
    logic        hdr_done, hdr_ok;

    logic        abort;
    logic [15:0] len_val;
    logic        len_bad;
    logic        last_pix;

    assign abort    = rx_er || !rx_dv;
    assign len_val  = {len_hi, rxd};
    assign len_bad  = (len_val == 16'd0) || (len_val > MAX_PIX_W);
    assign last_pix = (pix_cnt + 16'd1) == pix_n;

    gmii_rx_hdr_filter #(
        .MAC_ADDR (MAC_ADDR),
        .ETH_TYPE (ETH_TYPE)
    ) u_hdr_filter (
        .clk      (rx_clk),
        .rst      (sys_rst),
        .clr      (state != ST_HDR),
        .en       ((state == ST_HDR) && !abort),
        .rx_byte  (rxd),
        .hdr_done (hdr_done),
        .hdr_ok   (hdr_ok)
    );

    // Next-state and next-cycle strobes for the frame FSM.
    always_comb begin
        state_nx = state;
        wr_en_nx = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_dv)
                    state_nx = (rxd == PREAMBLE_BYTE) ? ST_PRE : ST_DROP;
            end
            ST_PRE: begin
                if (!rx_dv)
                    state_nx = ST_IDLE;
                else if (rxd == PREAMBLE_BYTE)
                    state_nx = ST_PRE;
                else if ((rxd == SFD_BYTE) && (pre_cnt >= PRE_MIN_W))
                    state_nx = ST_HDR;
                else
                    state_nx = ST_DROP;
            end
            ST_HDR: begin
                if (abort)
                    state_nx = rx_dv ? ST_DROP : ST_IDLE;
                else if (hdr_done)
                    state_nx = hdr_ok ? ST_LEN : ST_DROP;
            end
            ST_LEN: begin
                if (abort) begin
                    err_nx   = 1'b1;
                    state_nx = rx_dv ? ST_DROP : ST_IDLE;
                end else if (len_ph) begin
                    err_nx   = len_bad;
                    state_nx = len_bad ? ST_DROP : ST_PIX;
                end
            end
            ST_PIX: begin
                if (abort) begin
                    err_nx   = 1'b1;
                    state_nx = rx_dv ? ST_DROP : ST_IDLE;
                end else if (phase == 2'd2) begin
                    wr_en_nx = !full;
                    if (last_pix) begin
                        done_nx  = 1'b1;
                        state_nx = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (!rx_dv)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register and registered output strobes.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_en      <= wr_en_nx;
            frame_done <= done_nx;
            frame_err  <= err_nx;
        end
    end

    // Preamble counter, length capture, pixel packing and overflow count.
    always_ff @(posedge rx_clk) begin
        if (sys_rst) begin
            pre_cnt <= '0;
            len_ph  <= 1'b0;
            len_hi  <= '0;
            pix_n   <= '0;
            pix_cnt <= '0;
            phase   <= '0;
            r_byte  <= '0;
            g_byte  <= '0;
            din     <= '0;
            ovf_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: pre_cnt <= 3'd1;
                ST_PRE: begin
                    if (rxd == PREAMBLE_BYTE && pre_cnt != 3'd7)
                        pre_cnt <= pre_cnt + 3'd1;
                end
                ST_HDR: len_ph <= 1'b0;
                ST_LEN: begin
                    if (!abort) begin
                        if (!len_ph) begin
                            len_hi <= rxd;
                            len_ph <= 1'b1;
                        end else begin
                            pix_n   <= len_val;
                            pix_cnt <= '0;
                            phase   <= '0;
                        end
                    end
                end
                ST_PIX: begin
                    if (!abort) begin
                        case (phase)
                            2'd0: begin
                                r_byte <= rxd;
                                phase  <= 2'd1;
                            end
                            2'd1: begin
                                g_byte <= rxd;
                                phase  <= 2'd2;
                            end
                            default: begin
                                phase   <= 2'd0;
                                pix_cnt <= pix_cnt + 16'd1;
                                if (!full)
                                    din <= {r_byte, g_byte, rxd};
                                else if (ovf_cnt != 16'hFFFF)
                                    ovf_cnt <= ovf_cnt + 16'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gmii_rx.md
Name: gmii_rx

Overview:
- GMII receive-side counterpart of gmii_tx; runs entirely in the PHY receive clock domain.
- Strips preamble/SFD, filters Ethernet frames by destination MAC and EtherType, reads a 16-bit pixel count, and reassembles 3-byte payload groups into 24-bit pixels.
- Pixels go to the write side of the downstream pixel FIFO (din/wr_en/full), mirroring the dout/rd_en/empty side consumed by gmii_tx.
- No FCS check; trailing bytes after the counted pixels are discarded.

Parameters:
- MAC_ADDR, 48'h00_37_FF_00_00_01, accepted destination MAC (broadcast FF:FF:FF:FF:FF:FF also accepted).
- ETH_TYPE, 16'h88B5, accepted EtherType.
- PRE_MIN, 4, minimum 0x55 preamble bytes required before SFD.
- MAX_PIX, 1280, largest legal pixel count.

Ports:
- rx_clk  in  1  GMII receive clock, 125 MHz; sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- rx_dv  in  1  GMII receive data valid.
- rx_er  in  1  GMII receive error.
- rxd  in  8  GMII receive data.
- full  in  1  FIFO full.
- din  out  24  pixel to FIFO, {R,G,B}.
- wr_en  out  1  FIFO write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse, frame accepted with all pixels received.
- frame_err  out  1  one-cycle pulse, frame aborted after header accepted.
- ovf_cnt  out  16  saturating count of pixels dropped on full.

Behaviour:
- Reset: state IDLE; din=0, wr_en=0, frame_done=0, frame_err=0, ovf_cnt=0; all byte/pixel counters cleared. Reset mid-frame is honoured immediately.
- All inputs are sampled on posedge rx_clk. FSM states: IDLE, PRE, HDR, LEN, PIX, DROP.
- IDLE:
  - rx_dv=1 and rxd=0x55 -> PRE, preamble count=1.
  - rx_dv=1 with any other byte -> DROP. This also covers reset released mid-frame.
- PRE:
  - 0x55 -> count++, saturating at 7.
  - 0xD5 with count>=PRE_MIN -> HDR.
  - 0xD5 with count<PRE_MIN, any other byte, or rx_dv=0 -> DROP/IDLE. No error pulse.
- HDR:
  - Bytes 0-5 compared against MAC_ADDR or all-ones; bytes 12-13 compared against ETH_TYPE, big-endian.
  - A mismatch is latched; at byte 13, any mismatch -> DROP, else -> LEN. No error pulse.
- LEN:
  - 2 bytes, big-endian N.
  - N=0 or N>MAX_PIX -> DROP with frame_err. Else -> PIX with pixel count=0 and byte phase=0.
- PIX:
  - Phase 0 -> R into din[23:16]; phase 1 -> G into [15:8]; phase 2 -> B into [7:0].
  - On a phase-2 sample: wr_en=1 in the next cycle with the complete din, provided full=0 in the phase-2 cycle.
  - If full=1 in that cycle: no write, ovf_cnt++ (saturating at 0xFFFF), pixel still counted.
  - Latency: third byte sampled at edge k -> wr_en high for exactly cycle k+1.
  - After pixel N: frame_done pulse in the same cycle as the last wr_en, then -> DROP (FCS and padding ignored).
- Abort: rx_er=1 or rx_dv=0 in HDR/LEN/PIX before completion:
  - After HDR (LEN, PIX): frame_err pulse; partial pixel discarded, never written.
  - In HDR: silent abort.
  - Next state is DROP if rx_dv=1, IDLE if rx_dv=0.
- DROP: stay until rx_dv=0, then IDLE. A back-to-back frame needs at least one rx_dv=0 cycle.
- rx_er in IDLE/PRE/DROP is ignored, apart from PRE failing on a bad byte.
- din holds its last value when wr_en=0.
- frame_done and frame_err are never asserted together.

Decomposition:
- Shared package gmii_pkg:
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, HDR_LEN=14, BCAST_MAC.
  - FSM state encoding, shared with gmii_tx.
- One natural sub-module, gmii_rx_hdr_filter: byte index plus MAC/EtherType compare, outputs hdr_done/hdr_ok.
- Preamble handling, LEN decode, pixel packing and the FSM stay in gmii_rx.

Test Plan:
- Good frame: 7x55, D5, dst=MAC_ADDR, type=88B5, N=0x0002, bytes 11 22 33 44 55 66 + 4 FCS -> wr_en twice, din=112233 then 445566, frame_done with the 2nd write, frame_err never.
- Filter: same frame with dst 00:00:00:00:00:02 -> no wr_en, no pulses. Broadcast dst -> 2 writes. Type 0800 -> no writes.
- full=1 held during the 2nd pixel's B byte -> only 112233 written, ovf_cnt=1, frame_done still pulses.
- Truncation: rx_dv drops after byte 55 of a 2-pixel frame -> one write (112233), frame_err pulse, state IDLE.
- rx_er asserted on the 1st pixel's G byte -> no writes, frame_err pulse; DROP until rx_dv low. A following good frame -> 2 writes.
- Reset mid-frame: sys_rst for 1 cycle during pixel bytes -> outputs zero. Remaining bytes are ignored until rx_dv low, then the next good frame is received correctly. Also N=0 -> frame_err only.
